// File: rtl/memory_unit_if.sv
// memory_unit_if -- CPU control strobes and program-loader handshake for
// memory_unit. The shared 8-bit tri-state data bus is not carried here; it
// stays a plain inout on memory_unit so bus resolution sits at the top level.
//
// Loader handshake: a byte moves from host to RAM on a rising edge of i_clk
// exactly when i_prog_valid and o_prog_ready are both high. The host holds
// i_prog_data stable while o_prog_ready is low; o_prog_ready is registered
// and depends only on loader state, never on i_prog_valid.
//
// Signals:
//   i_mar_write_n  active-low: latch bus into MAR
//   i_ram_read_n   active-low: drive mem[MAR] onto bus
//   i_ram_write_n  active-low: write bus into mem[MAR]
//   i_prog_mode    1 = loader owns RAM, CPU strobes ignored
//   i_prog_valid   loader byte valid
//   i_prog_data    loader byte
//   o_prog_ready   loader can accept a byte this cycle
//   o_prog_done    all 2**ADDR_W bytes loaded
//   o_mar          current MAR value
//   o_load_state   loader FSM state (debug): 0 IDLE, 1 LOAD, 2 DONE
interface memory_unit_if #(
    parameter int ADDR_W = 4
);
    logic              i_mar_write_n;
    logic              i_ram_read_n;
    logic              i_ram_write_n;
    logic              i_prog_mode;
    logic              i_prog_valid;
    logic [7:0]        i_prog_data;
    logic              o_prog_ready;
    logic              o_prog_done;
    logic [ADDR_W-1:0] o_mar;
    logic [1:0]        o_load_state;

    modport master (
        output i_mar_write_n, i_ram_read_n, i_ram_write_n,
        output i_prog_mode, i_prog_valid, i_prog_data,
        input  o_prog_ready, o_prog_done, o_mar, o_load_state
    );

    modport slave (
        input  i_mar_write_n, i_ram_read_n, i_ram_write_n,
        input  i_prog_mode, i_prog_valid, i_prog_data,
        output o_prog_ready, o_prog_done, o_mar, o_load_state
    );
endinterface

// File: rtl/memory_unit.sv
// memory_unit -- memory address register plus 2**ADDR_W x 8 RAM on the shared
// CPU bus, with a byte-stream loader that fills RAM from address 0 upward
// before the CPU runs.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_reset        asynchronous, active-high reset (RAM contents kept)
//   io_bus         shared 8-bit tri-state CPU bus
//   ctl            memory_unit_if.slave: CPU strobes, loader handshake,
//                  MAR and loader-state observation
//   o_parity_err   only with MEM_PARITY_EN: registered parity error of the
//                  word read on the previous edge
//
// Optional feature macro: MEM_PARITY_EN adds an even-parity bit per word
// and the o_parity_err output.
module memory_unit #(
    parameter int ADDR_W = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    inout  wire  [7:0]    io_bus,
`ifdef MEM_PARITY_EN
    output logic          o_parity_err,
`endif
    memory_unit_if.slave  ctl
);
    localparam int DEPTH = 1 << ADDR_W;
    // Pointer is one bit wider than the address so the final byte is
    // recognised without relying on wrap-around.
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W:0]   ptr, ptr_next;
    state_t            state, state_next;
    logic              load_fire;
    logic              prog_ready, prog_done;

    logic cpu_read, cpu_write, mar_load;

    assign cpu_read  = !ctl.i_ram_read_n && !ctl.i_prog_mode;
    // A read wins over a simultaneous write so the RAM never writes itself.
    assign cpu_write = !ctl.i_ram_write_n && ctl.i_ram_read_n && !ctl.i_prog_mode && !i_reset;
    assign mar_load  = !ctl.i_mar_write_n && !ctl.i_prog_mode;

    assign io_bus = (cpu_read && !i_reset) ? mem[mar] : 8'hzz;

    assign ctl.o_mar        = mar;
    assign ctl.o_prog_ready = prog_ready;
    assign ctl.o_prog_done  = prog_done;
    assign ctl.o_load_state = state;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctl.i_prog_mode) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                end
            end
            LOAD: begin
                if (!ctl.i_prog_mode) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else if (ctl.i_prog_valid) begin
                    load_fire = 1'b1;
                    ptr_next  = ptr + ONE;
                    if (ptr == LAST) state_next = DONE;
                end
            end
            DONE: begin
                if (!ctl.i_prog_mode) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            mar        <= '0;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            prog_ready <= (state_next == LOAD);
            prog_done  <= (state_next == DONE);
            if (mar_load) mar <= io_bus[ADDR_W-1:0];
        end
    end

    // The CPU write uses the MAR value from before the edge, so a
    // simultaneous MAR load does not redirect it.
    always_ff @(posedge i_clk) begin
        if (load_fire) begin
            mem[ptr[ADDR_W-1:0]] <= ctl.i_prog_data;
        end else if (cpu_write) begin
            mem[mar] <= io_bus;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (load_fire) begin
            par_mem[ptr[ADDR_W-1:0]] <= ^ctl.i_prog_data;
        end else if (cpu_write) begin
            par_mem[mar] <= ^io_bus;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= cpu_read && ((^mem[mar]) != par_mem[mar]);
        end
    end
`endif
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit -- directed bench for memory_unit. Stimulus tasks push the
// byte each CPU read should return into exp_q; a monitor on the falling edge
// pops and compares whenever a CPU read is presented on the bus.
module tb_memory_unit;
    localparam int ADDR_W = 4;

    logic       i_clk;
    logic       i_reset;
    logic [7:0] tb_drv;
    logic       tb_oe;
    wire  [7:0] bus;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    assign bus = tb_oe ? tb_drv : 8'hzz;

    // Pull-ups make a released bus read as 8'hFF.
    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup pu (bus[b]);
    end

    memory_unit_if #(.ADDR_W(ADDR_W)) ctl ();

`ifdef MEM_PARITY_EN
    logic parity_err;
`endif

    memory_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .io_bus       (bus),
`ifdef MEM_PARITY_EN
        .o_parity_err (parity_err),
`endif
        .ctl          (ctl.master)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every CPU read presented on the bus is compared with the head
    // of the expected queue.
    always @(negedge i_clk) begin
        if (!i_reset && !ctl.i_ram_read_n && !ctl.i_prog_mode) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_read_unexpected: got %0h expected no read at %0t", bus, $time);
            end else begin
                check("bus_read", {24'd0, bus}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_mar(input logic [7:0] a);
        tb_drv = a;
        tb_oe  = 1'b1;
        ctl.i_mar_write_n = 1'b0;
        tick();
        ctl.i_mar_write_n = 1'b1;
        tb_oe  = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp);
        set_mar(a);
        exp_q.push_back(exp);
        ctl.i_ram_read_n = 1'b0;
        tick();
        ctl.i_ram_read_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent;
        int rdy;
        int guard;

        n_checks = 0;
        n_fail   = 0;
        i_reset  = 1'b1;
        tb_drv   = 8'h00;
        tb_oe    = 1'b0;
        ctl.i_mar_write_n = 1'b1;
        ctl.i_ram_read_n  = 1'b1;
        ctl.i_ram_write_n = 1'b1;
        ctl.i_prog_mode   = 1'b0;
        ctl.i_prog_valid  = 1'b0;
        ctl.i_prog_data   = 8'h00;

        tick();
        tick();
        check("rst_ready", {31'd0, ctl.o_prog_ready}, 32'd0);
        check("rst_done",  {31'd0, ctl.o_prog_done},  32'd0);
        check("rst_mar",   {28'd0, ctl.o_mar},        32'd0);
        check("rst_state", {30'd0, ctl.o_load_state}, 32'd0);
        i_reset = 1'b0;
        tick();

        // Stream 16 bytes 10..1F, then offer AA which must be ignored.
        ctl.i_prog_mode  = 1'b1;
        ctl.i_prog_valid = 1'b1;
        ctl.i_prog_data  = 8'h10;
        sent = 0;
        rdy  = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            ctl.i_prog_data = (sent < 16) ? 8'(8'h10 + sent) : 8'hAA;
            if (ctl.o_prog_ready) begin
                rdy++;
                sent++;
            end
        end
        check("load_ready_cycles", rdy, 32'd16);
        check("load_done",  {31'd0, ctl.o_prog_done},  32'd1);
        check("load_ready_after_done", {31'd0, ctl.o_prog_ready}, 32'd0);
        ctl.i_prog_valid = 1'b0;
        ctl.i_prog_mode  = 1'b0;
        tick();
        check("done_cleared", {31'd0, ctl.o_prog_done}, 32'd0);

        // MAR load then zero-latency read; released bus afterwards.
        set_mar(8'h03);
        check("mar_is_3", {28'd0, ctl.o_mar}, 32'd3);
        exp_q.push_back(8'h13);
        ctl.i_ram_read_n = 1'b0;
        tick();
        ctl.i_ram_read_n = 1'b1;
        #1;
        check("bus_released", {24'd0, bus}, 32'hFF);
        cpu_read(8'h00, 8'h10);
        cpu_read(8'h0F, 8'h1F);
        // Upper bus bits are ignored by the MAR.
        set_mar(8'hF7);
        check("mar_upper_ignored", {28'd0, ctl.o_mar}, 32'd7);

        // Simultaneous MAR load and write: write lands at the old MAR.
        set_mar(8'h05);
        tb_drv = 8'h5A;
        tb_oe  = 1'b1;
        ctl.i_ram_write_n = 1'b0;
        ctl.i_mar_write_n = 1'b0;
        tick();
        ctl.i_ram_write_n = 1'b1;
        ctl.i_mar_write_n = 1'b1;
        tb_oe = 1'b0;
        check("mar_after_wr", {28'd0, ctl.o_mar}, 32'hA);
        cpu_read(8'h0A, 8'h1A);
        cpu_read(8'h05, 8'h5A);

        // Read and write together at MAR=2: read wins, no write.
        set_mar(8'h02);
        exp_q.push_back(8'h12);
        ctl.i_ram_read_n  = 1'b0;
        ctl.i_ram_write_n = 1'b0;
        tick();
        ctl.i_ram_read_n  = 1'b1;
        ctl.i_ram_write_n = 1'b1;
        cpu_read(8'h02, 8'h12);

        // CPU strobes are ignored while the loader owns the RAM.
        ctl.i_prog_mode = 1'b1;
        tb_drv = 8'h09;
        tb_oe  = 1'b1;
        ctl.i_mar_write_n = 1'b0;
        ctl.i_ram_write_n = 1'b0;
        tick();
        ctl.i_mar_write_n = 1'b1;
        ctl.i_ram_write_n = 1'b1;
        tb_oe = 1'b0;
        check("mar_ignored_in_prog", {28'd0, ctl.o_mar}, 32'd2);
        ctl.i_prog_mode = 1'b0;
        tick();
        cpu_read(8'h02, 8'h12);

        // Reset after 7 loader bytes 60..66.
        ctl.i_prog_mode  = 1'b1;
        ctl.i_prog_valid = 1'b1;
        ctl.i_prog_data  = 8'h60;
        sent  = 0;
        guard = 0;
        while (sent < 7 && guard < 40) begin
            tick();
            guard++;
            if (ctl.o_prog_ready) begin
                ctl.i_prog_data = 8'(8'h60 + sent);
                sent++;
            end
        end
        check("partial_sent", sent, 32'd7);
        tick();
        i_reset = 1'b1;
        ctl.i_prog_mode  = 1'b0;
        ctl.i_prog_valid = 1'b0;
        ctl.i_ram_read_n = 1'b0;
        #2;
        check("rst_mid_ready", {31'd0, ctl.o_prog_ready}, 32'd0);
        check("rst_mid_done",  {31'd0, ctl.o_prog_done},  32'd0);
        check("rst_mid_mar",   {28'd0, ctl.o_mar},        32'd0);
        check("rst_bus_released", {24'd0, bus}, 32'hFF);
        ctl.i_ram_read_n = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();

        // Re-enter loader: the first byte must land at address 0.
        ctl.i_prog_mode  = 1'b1;
        ctl.i_prog_valid = 1'b1;
        ctl.i_prog_data  = 8'hC0;
        tick();
        check("reload_ready", {31'd0, ctl.o_prog_ready}, 32'd1);
        tick();
        ctl.i_prog_mode  = 1'b0;
        ctl.i_prog_valid = 1'b0;
        tick();
        check("reload_idle", {30'd0, ctl.o_load_state}, 32'd0);
        cpu_read(8'h00, 8'hC0);
        cpu_read(8'h01, 8'h61);
        cpu_read(8'h06, 8'h66);
        cpu_read(8'h07, 8'h17);

`ifdef MEM_PARITY_EN
        dut.par_mem[4] = ~dut.par_mem[4];
        cpu_read(8'h04, 8'h14);
        check("parity_err_set", {31'd0, parity_err}, 32'd1);
        cpu_read(8'h03, 8'h13);
        check("parity_err_clear", {31'd0, parity_err}, 32'd0);
`endif

        tick();
        check("exp_q_drained", exp_q.size(), 32'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
